// File: rtl/a7800_pkg.sv
// ============================================================================
// a7800_pkg : shared types and A78 header layout for the 7800 ROM loader
// Revision  : 1.0
// ============================================================================
`default_nettype none

package a7800_pkg;

  typedef enum logic [1:0] {
    TGT_CART      = 2'd0,
    TGT_BIOS_NTSC = 2'd1,
    TGT_BIOS_PAL  = 2'd2,
    TGT_NONE      = 2'd3
  } tgt_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_HDR   = 3'd2,
    ST_BODY  = 3'd3,
    ST_DONE  = 3'd4
  } loader_state_t;

  localparam int OFF_SIG_FIRST = 1;
  localparam int OFF_SIG_LAST  = 5;
  localparam int OFF_SIZE      = 49;
  localparam int OFF_FLAGS     = 53;
  localparam int OFF_JOY0      = 55;
  localparam int OFF_JOY1      = 56;
  localparam int OFF_REGION    = 57;
  localparam int OFF_SAVE      = 58;

  localparam logic [39:0] SIG_ATARI = 40'h41_54_41_52_49;

  function automatic tgt_t decode_target(input logic [7:0] idx);
    if (idx[5:0] == 6'd1)                      return TGT_CART;
    if (idx[5:0] == 6'd0 && idx[7:6] == 2'd0)  return TGT_BIOS_NTSC;
    if (idx[5:0] == 6'd0 && idx[7:6] == 2'd1)  return TGT_BIOS_PAL;
    return TGT_NONE;
  endfunction

endpackage

`default_nettype wire

// File: rtl/a78_header_parser.sv
// ============================================================================
// a78_header_parser : captures A78 header fields and checks the "ATARI" tag
// Revision          : 1.0
// ============================================================================
`default_nettype none

module a78_header_parser
  import a7800_pkg::*;
(
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_we,
  input  logic [24:0] byte_addr,
  input  logic [7:0]  byte_data,
  output logic        cart_is_7800,
  output logic [31:0] hdr_size,
  output logic [15:0] cart_flags,
  output logic [15:0] joy_type,
  output logic        cart_region,
  output logic [7:0]  save_type
);

  logic [39:0] r_sig;
  logic        r_is_7800;
  logic [31:0] r_hdr_size;
  logic [15:0] r_flags;
  logic [15:0] r_joy;
  logic        r_region;
  logic [7:0]  r_save;

  always_ff @(posedge clk_sys) begin
    if (reset || clear) begin
      r_sig      <= '0;
      r_is_7800  <= 1'b0;
      r_hdr_size <= '0;
      r_flags    <= '0;
      r_joy      <= '0;
      r_region   <= 1'b0;
      r_save     <= '0;
    end else if (byte_we) begin
      case (byte_addr)
        25'(OFF_SIG_FIRST):     r_sig[39:32] <= byte_data;
        25'(OFF_SIG_FIRST + 1): r_sig[31:24] <= byte_data;
        25'(OFF_SIG_FIRST + 2): r_sig[23:16] <= byte_data;
        25'(OFF_SIG_FIRST + 3): r_sig[15:8]  <= byte_data;
        // Last tag byte is compared straight from the bus so the flag lands one cycle later.
        25'(OFF_SIG_LAST): begin
          r_sig[7:0] <= byte_data;
          r_is_7800  <= ({r_sig[39:8], byte_data} == SIG_ATARI);
        end
        25'(OFF_SIZE):          r_hdr_size[31:24] <= byte_data;
        25'(OFF_SIZE + 1):      r_hdr_size[23:16] <= byte_data;
        25'(OFF_SIZE + 2):      r_hdr_size[15:8]  <= byte_data;
        25'(OFF_SIZE + 3):      r_hdr_size[7:0]   <= byte_data;
        25'(OFF_FLAGS):         r_flags[15:8] <= byte_data;
        25'(OFF_FLAGS + 1):     r_flags[7:0]  <= byte_data;
        25'(OFF_JOY0):          r_joy[15:8]   <= byte_data;
        25'(OFF_JOY1):          r_joy[7:0]    <= byte_data;
        25'(OFF_REGION):        r_region      <= byte_data[0];
        25'(OFF_SAVE):          r_save        <= byte_data;
        default: ;
      endcase
    end
  end

  assign cart_is_7800 = r_is_7800;
  assign hdr_size     = r_hdr_size;
  assign cart_flags   = r_flags;
  assign joy_type     = r_joy;
  assign cart_region  = r_region;
  assign save_type    = r_save;

endmodule

`default_nettype wire

// File: rtl/rom_loader.sv
// ============================================================================
// rom_loader : routes HPS ioctl downloads to cart / BIOS memories, strips the
//              A78 header and holds the core until the first cart is loaded
// Revision   : 1.0
// ============================================================================
`default_nettype none

module rom_loader
  import a7800_pkg::*;
#(
  parameter int CART_AW = 19,
  parameter int BIOS_AW = 14,
  parameter int HDR_LEN = 128,
  parameter int NUM_TGT = 3
) (
  input  logic               clk_sys,
  input  logic               reset,
  input  logic               ioctl_download,
  input  logic [7:0]         ioctl_index,
  input  logic [24:0]        ioctl_addr,
  input  logic [7:0]         ioctl_dout,
  input  logic               ioctl_wr,
  output logic [CART_AW-1:0] mem_addr,
  output logic [7:0]         mem_data,
  output logic [NUM_TGT-1:0] mem_we,
  output logic               cart_is_7800,
  output logic [31:0]        cart_size,
  output logic [31:0]        hdr_size,
  output logic [15:0]        cart_flags,
  output logic [15:0]        joy_type,
  output logic               cart_region,
  output logic [7:0]         save_type,
  output logic               overflow,
  output logic               load_done,
  output logic               hold
);

  loader_state_t      r_state, w_state_next;
  tgt_t               r_tgt;
  logic               r_dl_prev;
  logic [NUM_TGT-1:0] r_mem_we;
  logic [CART_AW-1:0] r_mem_addr;
  logic [7:0]         r_mem_data;
  logic               r_overflow;
  logic [24:0]        r_last_addr;
  logic               r_got_byte;
  logic [31:0]        r_cart_size;
  logic               r_hold;

  logic               w_dl_rise;
  logic               w_byte;
  logic               w_cart_byte;
  logic               w_clear;
  logic [24:0]        w_raddr;
  logic [25:0]        w_limit;
  logic               w_fits;
  logic [NUM_TGT-1:0] w_we_vec;
  logic [31:0]        w_end;
  logic [31:0]        w_hdr;
  logic [31:0]        w_size;

  assign w_dl_rise   = ioctl_download & ~r_dl_prev;
  assign w_byte      = ioctl_wr & ioctl_download & (r_tgt != TGT_NONE) &
                       (r_state inside {ST_START, ST_HDR, ST_BODY});
  assign w_cart_byte = w_byte & (r_tgt == TGT_CART);
  assign w_clear     = (r_state == ST_START) & (r_tgt == TGT_CART);

  // Payload past a recognised header lands on top of the raw header bytes.
  assign w_raddr = (r_tgt == TGT_CART && cart_is_7800 && ioctl_addr >= 25'(HDR_LEN))
                   ? ioctl_addr - 25'(HDR_LEN) : ioctl_addr;
  assign w_limit = (r_tgt == TGT_CART) ? (26'd1 << CART_AW) : (26'd1 << BIOS_AW);
  assign w_fits  = ({1'b0, w_raddr} < w_limit);

  always_comb begin
    w_we_vec = '0;
    for (int i = 0; i < NUM_TGT; i++) begin
      w_we_vec[i] = (int'(r_tgt) == i);
    end
  end

  always_comb begin
    w_end  = {7'd0, r_last_addr} + 32'd1;
    w_hdr  = cart_is_7800 ? 32'(HDR_LEN) : 32'd0;
    w_size = (!r_got_byte || w_end <= w_hdr) ? 32'd0 : w_end - w_hdr;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_dl_rise) w_state_next = ST_START;
      ST_START: w_state_next = (r_tgt == TGT_CART) ? ST_HDR : ST_BODY;
      ST_HDR: begin
        if (!ioctl_download)
          w_state_next = ST_DONE;
        else if (w_cart_byte && ioctl_addr >= 25'(HDR_LEN - 1))
          w_state_next = ST_BODY;
      end
      ST_BODY:  if (!ioctl_download) w_state_next = ST_DONE;
      ST_DONE:  w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_tgt       <= TGT_NONE;
      // Pretend the window was already open so a download in flight is not re-armed.
      r_dl_prev   <= 1'b1;
      r_mem_we    <= '0;
      r_mem_addr  <= '0;
      r_mem_data  <= '0;
      r_overflow  <= 1'b0;
      r_last_addr <= '0;
      r_got_byte  <= 1'b0;
      r_cart_size <= '0;
      r_hold      <= 1'b1;
    end else begin
      r_state   <= w_state_next;
      r_dl_prev <= ioctl_download;
      if (r_state == ST_IDLE && w_dl_rise)
        r_tgt <= decode_target(ioctl_index);

      r_mem_we <= (w_byte && w_fits) ? w_we_vec : '0;
      if (w_byte && w_fits) begin
        r_mem_addr <= w_raddr[CART_AW-1:0];
        r_mem_data <= ioctl_dout;
      end

      if (r_state == ST_START) begin
        r_got_byte  <= 1'b0;
        r_last_addr <= '0;
      end
      if (w_clear)
        r_overflow <= 1'b0;
      if (w_byte && !w_fits)
        r_overflow <= 1'b1;
      if (w_cart_byte) begin
        r_last_addr <= ioctl_addr;
        r_got_byte  <= 1'b1;
      end

      if (r_state == ST_DONE && r_tgt == TGT_CART) begin
        r_cart_size <= w_size;
        r_hold      <= 1'b0;
      end
    end
  end

  a78_header_parser u_hdr (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .clear        (w_clear),
    .byte_we      (w_cart_byte),
    .byte_addr    (ioctl_addr),
    .byte_data    (ioctl_dout),
    .cart_is_7800 (cart_is_7800),
    .hdr_size     (hdr_size),
    .cart_flags   (cart_flags),
    .joy_type     (joy_type),
    .cart_region  (cart_region),
    .save_type    (save_type)
  );

  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_data  = r_mem_data;
  assign overflow  = r_overflow;
  assign cart_size = r_cart_size;
  assign hold      = r_hold;
  assign load_done = (r_state == ST_DONE);

endmodule

`default_nettype wire
